// File: rtl/mem_burst_interface_pkg.sv
// Shared constants for the cache-to-RAM burst interface.
//   - default widths and RAM read latency
//   - FSM state encoding
//   - helpers that derive the beat count and the beat-index width
package mem_burst_interface_pkg;

  localparam int DEF_ADDR_WIDTH  = 16;
  localparam int DEF_LINE_WIDTH  = 128;
  localparam int DEF_BUS_WIDTH   = 16;
  localparam int DEF_RAM_LATENCY = 2;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RD   = 2'd1,
    S_WR   = 2'd2,
    S_DONE = 2'd3
  } state_t;

  // Bus words per cache line.
  function automatic int calc_beats(input int line_w, input int bus_w);
    return line_w / bus_w;
  endfunction

  // Width of a beat index; at least 1 so vectors stay legal.
  function automatic int calc_idx_w(input int beats);
    return (beats > 1) ? $clog2(beats) : 1;
  endfunction

endpackage

// File: rtl/mem_beat_sequencer.sv
// Beat issue sequencer: after a start pulse it walks the beat index
// 0..BEATS-1, one beat per cycle, and raises the read or write strobe
// selected by the direction flag latched at start.
// Ports:
//   i_clk, i_rst      clock, async active-high reset
//   i_start           one-cycle start pulse (acceptance edge)
//   i_dir_wr          1 = write burst, 0 = read burst
//   o_beat_idx        current beat index
//   o_rd_stb/o_wr_stb beat strobes, high for BEATS cycles after start
//   o_last            high on the final beat
module mem_beat_sequencer #(
  parameter int BEATS = 8,
  parameter int IDXW  = 3
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_start,
  input  logic            i_dir_wr,
  output logic [IDXW-1:0] o_beat_idx,
  output logic            o_rd_stb,
  output logic            o_wr_stb,
  output logic            o_last
);

  logic            r_active;
  logic            r_dir_wr;
  logic [IDXW-1:0] r_idx;
  logic            w_last;

  assign w_last = r_active && (r_idx == IDXW'(BEATS - 1));

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_active <= 1'b0;
      r_dir_wr <= 1'b0;
      r_idx    <= '0;
    end else if (i_start) begin
      r_active <= 1'b1;
      r_dir_wr <= i_dir_wr;
      r_idx    <= '0;
    end else if (r_active) begin
      // BEATS is a power of two, so the index wraps back to 0 by itself.
      r_idx <= r_idx + IDXW'(1);
      if (w_last) r_active <= 1'b0;
    end
  end

  assign o_beat_idx = r_idx;
  assign o_rd_stb   = r_active && !r_dir_wr;
  assign o_wr_stb   = r_active &&  r_dir_wr;
  assign o_last     = w_last;

endmodule

// File: rtl/mem_burst_interface.sv
// Cache-to-RAM burst interface. Moves one cache line as BEATS bus words.
// Reads are issued back-to-back and captured RAM_LATENCY cycles later;
// writes stream one beat per cycle. Each transfer ends with a one-cycle ACK.
// Ports:
//   CLK, RST                 clock, async active-high reset
//   SIG_RD, SIG_WR           line requests (write wins), sampled in IDLE
//   IN_ADDR, IN_DATA         word address in line, line to write
//   OUT_DATA                 last line read, held until the next read
//   ACK, BUSY                completion pulse, transfer in progress
//   OUT_RAM_ADDR/DATA/RD/WR  RAM word address, write data, strobes
//   IN_RAM_DATA              RAM read data
module mem_burst_interface
  import mem_burst_interface_pkg::*;
#(
  parameter int ADDR_WIDTH  = DEF_ADDR_WIDTH,
  parameter int LINE_WIDTH  = DEF_LINE_WIDTH,
  parameter int BUS_WIDTH   = DEF_BUS_WIDTH,
  parameter int RAM_LATENCY = DEF_RAM_LATENCY
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  SIG_RD,
  input  logic                  SIG_WR,
  input  logic [ADDR_WIDTH-1:0] IN_ADDR,
  input  logic [LINE_WIDTH-1:0] IN_DATA,
  output logic [LINE_WIDTH-1:0] OUT_DATA,
  output logic                  ACK,
  output logic                  BUSY,
  output logic [ADDR_WIDTH-1:0] OUT_RAM_ADDR,
  output logic [BUS_WIDTH-1:0]  OUT_RAM_DATA,
  output logic                  OUT_RAM_RD,
  output logic                  OUT_RAM_WR,
  input  logic [BUS_WIDTH-1:0]  IN_RAM_DATA
);

  localparam int BEATS = calc_beats(LINE_WIDTH, BUS_WIDTH);
  localparam int IDXW  = calc_idx_w(BEATS);

  if (LINE_WIDTH % BUS_WIDTH != 0) begin : g_chk_mult
    $error("LINE_WIDTH must be a multiple of BUS_WIDTH");
  end
  if (BEATS < 2 || (BEATS & (BEATS - 1)) != 0) begin : g_chk_beats
    $error("BEATS must be a power of 2 and at least 2");
  end
  if (RAM_LATENCY < 0) begin : g_chk_lat
    $error("RAM_LATENCY must not be negative");
  end

  state_t                r_state, w_state_nxt;
  logic                  w_start, w_start_wr;
  logic [ADDR_WIDTH-1:0] r_base;
  logic [LINE_WIDTH-1:0] r_wline, r_rbuf, w_rbuf_nxt, r_out_data;
  logic [IDXW-1:0]       w_beat_idx, r_cap_idx;
  logic                  w_rd_stb, w_wr_stb, w_seq_last;
  logic                  w_cap, w_cap_last;

  // ---------------- FSM ----------------
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_start     = 1'b0;
    w_start_wr  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (SIG_WR) begin
          w_state_nxt = S_WR;
          w_start     = 1'b1;
          w_start_wr  = 1'b1;
        end else if (SIG_RD) begin
          w_state_nxt = S_RD;
          w_start     = 1'b1;
        end
      end
      // Reads finish on the last capture, not the last issue.
      S_RD:    if (w_cap_last) w_state_nxt = S_DONE;
      S_WR:    if (w_seq_last) w_state_nxt = S_DONE;
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // ---------------- request latch ----------------
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_base  <= '0;
      r_wline <= '0;
    end else if (w_start) begin
      r_base <= IN_ADDR & ~ADDR_WIDTH'(BEATS - 1);
      if (w_start_wr) r_wline <= IN_DATA;
    end
  end

  // ---------------- issue side ----------------
  mem_beat_sequencer #(
    .BEATS (BEATS),
    .IDXW  (IDXW)
  ) u_seq (
    .i_clk      (CLK),
    .i_rst      (RST),
    .i_start    (w_start),
    .i_dir_wr   (w_start_wr),
    .o_beat_idx (w_beat_idx),
    .o_rd_stb   (w_rd_stb),
    .o_wr_stb   (w_wr_stb),
    .o_last     (w_seq_last)
  );

  // ---------------- capture side ----------------
  // The read strobe delayed by RAM_LATENCY marks the cycle its word is valid.
  if (RAM_LATENCY == 0) begin : g_nolat
    assign w_cap = w_rd_stb;
  end else begin : g_lat
    logic [RAM_LATENCY-1:0] r_vld_pipe;
    always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
        r_vld_pipe <= '0;
      end else begin
        r_vld_pipe[0] <= w_rd_stb;
        for (int i = 1; i < RAM_LATENCY; i++) r_vld_pipe[i] <= r_vld_pipe[i-1];
      end
    end
    assign w_cap = r_vld_pipe[RAM_LATENCY-1];
  end

  assign w_cap_last = w_cap && (r_cap_idx == IDXW'(BEATS - 1));

  always_comb begin
    w_rbuf_nxt = r_rbuf;
    w_rbuf_nxt[r_cap_idx*BUS_WIDTH +: BUS_WIDTH] = IN_RAM_DATA;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_rbuf     <= '0;
      r_cap_idx  <= '0;
      r_out_data <= '0;
    end else begin
      if (w_cap) begin
        r_rbuf    <= w_rbuf_nxt;
        r_cap_idx <= r_cap_idx + IDXW'(1);
      end
      // Publish the merged line on the final capture so it is visible with ACK.
      if (w_cap_last) r_out_data <= w_rbuf_nxt;
    end
  end

  // ---------------- outputs ----------------
  // base is line-aligned, so OR-ing the beat index equals base+k and the
  // burst stays inside its line.
  assign OUT_RAM_ADDR = (w_rd_stb || w_wr_stb) ? (r_base | ADDR_WIDTH'(w_beat_idx)) : '0;
  assign OUT_RAM_DATA = w_wr_stb ? r_wline[w_beat_idx*BUS_WIDTH +: BUS_WIDTH] : '0;
  assign OUT_RAM_RD   = w_rd_stb;
  assign OUT_RAM_WR   = w_wr_stb;
  assign ACK          = (r_state == S_DONE);
  assign BUSY         = (r_state != S_IDLE);
  assign OUT_DATA     = r_out_data;

endmodule

// File: tb/tb_mem_burst_interface.sv
// Bench for mem_burst_interface: default instance (16-bit bus, latency 2)
// and a sweep instance (32-bit bus, latency 0). RAM models return a word
// derived from the address and a per-transaction salt; expected bus
// activity and lines are computed from the burst rules cycle by cycle.
module tb_mem_burst_interface;

  logic         CLK = 1'b0;
  logic         RST;
  logic         sig_rd_a, sig_wr_a, sig_rd_b, sig_wr_b;
  logic [15:0]  in_addr;
  logic [127:0] in_data;
  logic [15:0]  salt;

  logic [127:0] out_data_a, out_data_b;
  logic         ack_a, busy_a, ram_rd_a, ram_wr_a;
  logic         ack_b, busy_b, ram_rd_b, ram_wr_b;
  logic [15:0]  ram_addr_a, ram_addr_b;
  logic [15:0]  ram_wd_a, in_ram_a;
  logic [31:0]  ram_wd_b, in_ram_b;
  logic [15:0]  ram_d1, ram_d2;

  logic [127:0] exp_out [2];
  int n_chk = 0;
  int n_err = 0;

  always #5 CLK = ~CLK;

  mem_burst_interface u_dut_a (
    .CLK(CLK), .RST(RST), .SIG_RD(sig_rd_a), .SIG_WR(sig_wr_a),
    .IN_ADDR(in_addr), .IN_DATA(in_data), .OUT_DATA(out_data_a),
    .ACK(ack_a), .BUSY(busy_a), .OUT_RAM_ADDR(ram_addr_a),
    .OUT_RAM_DATA(ram_wd_a), .OUT_RAM_RD(ram_rd_a), .OUT_RAM_WR(ram_wr_a),
    .IN_RAM_DATA(in_ram_a)
  );

  mem_burst_interface #(.BUS_WIDTH(32), .RAM_LATENCY(0)) u_dut_b (
    .CLK(CLK), .RST(RST), .SIG_RD(sig_rd_b), .SIG_WR(sig_wr_b),
    .IN_ADDR(in_addr), .IN_DATA(in_data), .OUT_DATA(out_data_b),
    .ACK(ack_b), .BUSY(busy_b), .OUT_RAM_ADDR(ram_addr_b),
    .OUT_RAM_DATA(ram_wd_b), .OUT_RAM_RD(ram_rd_b), .OUT_RAM_WR(ram_wr_b),
    .IN_RAM_DATA(in_ram_b)
  );

  // RAM A: word = addr ^ salt, delivered two cycles after the address.
  always @(posedge CLK) begin
    ram_d1 <= ram_addr_a ^ salt;
    ram_d2 <= ram_d1;
  end
  assign in_ram_a = ram_d2;
  // RAM B: zero latency, word = {addr ^ salt, addr}.
  assign in_ram_b = {ram_addr_b ^ salt, ram_addr_b};

  function automatic logic [31:0] ram_word(input int inst, input logic [15:0] a);
    if (inst == 0) return {16'h0, a ^ salt};
    return {a ^ salt, a};
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %h expected %h", tag, $time, obs, exp);
    end
  endtask

  task automatic sample(input int inst, output logic busy, output logic ack,
                        output logic rd, output logic wr, output logic [15:0] addr,
                        output logic [31:0] wd, output logic [127:0] line);
    if (inst == 0) begin
      busy = busy_a; ack = ack_a; rd = ram_rd_a; wr = ram_wr_a;
      addr = ram_addr_a; wd = {16'h0, ram_wd_a}; line = out_data_a;
    end else begin
      busy = busy_b; ack = ack_b; rd = ram_rd_b; wr = ram_wr_b;
      addr = ram_addr_b; wd = ram_wd_b; line = out_data_b;
    end
  endtask

  task automatic chk_all_zero(input int inst, input string tag);
    logic o_busy, o_ack, o_rd, o_wr;
    logic [15:0] o_addr;
    logic [31:0] o_wd;
    logic [127:0] o_line;
    sample(inst, o_busy, o_ack, o_rd, o_wr, o_addr, o_wd, o_line);
    chk({tag, " busy"}, o_busy, 0);
    chk({tag, " ack"}, o_ack, 0);
    chk({tag, " rd"}, o_rd, 0);
    chk({tag, " wr"}, o_wr, 0);
    chk({tag, " addr"}, o_addr, 0);
    chk({tag, " wdata"}, o_wd, 0);
    chk({tag, " line"}, o_line, 0);
  endtask

  // One full transaction. hold=1 leaves the requests up during the burst and
  // drops only SIG_WR in the ACK cycle, so a held SIG_RD chains a read.
  task automatic do_txn(input int inst, input bit rd, input bit wr,
                        input logic [15:0] addr, input logic [127:0] data, input bit hold);
    int bw, beats, lat;
    logic [15:0] base, ea;
    logic [127:0] line, sh;
    logic [31:0] ewd;
    logic o_busy, o_ack, o_rd, o_wr;
    logic [15:0] o_addr;
    logic [31:0] o_wd;
    logic [127:0] o_line;
    bw    = (inst == 0) ? 16 : 32;
    beats = 128 / bw;
    lat   = wr ? beats + 1 : beats + ((inst == 0) ? 2 : 0) + 1;
    base  = addr & ~16'(beats - 1);
    line  = '0;
    for (int k = beats - 1; k >= 0; k--)
      line = (line << bw) | 128'(ram_word(inst, base + 16'(k)));

    @(negedge CLK);
    sample(inst, o_busy, o_ack, o_rd, o_wr, o_addr, o_wd, o_line);
    chk("idle before request", o_busy, 0);
    if (inst == 0) begin sig_rd_a = rd; sig_wr_a = wr; end
    else           begin sig_rd_b = rd; sig_wr_b = wr; end
    in_addr = addr;
    in_data = data;
    @(posedge CLK);
    for (int c = 1; c <= lat; c++) begin
      @(negedge CLK);
      if (c == 1 && !hold) begin
        sig_rd_a = 0; sig_wr_a = 0; sig_rd_b = 0; sig_wr_b = 0;
      end
      sample(inst, o_busy, o_ack, o_rd, o_wr, o_addr, o_wd, o_line);
      ea  = (c <= beats) ? base + 16'(c - 1) : 16'h0;
      sh  = data >> ((c - 1) * bw);
      ewd = (wr && c <= beats) ? ((bw == 32) ? sh[31:0] : {16'h0, sh[15:0]}) : 32'h0;
      if (!wr && c == lat) exp_out[inst] = line;
      chk($sformatf("i%0d c%0d busy", inst, c), o_busy, 1);
      chk($sformatf("i%0d c%0d ack", inst, c), o_ack, c == lat);
      chk($sformatf("i%0d c%0d ram_rd", inst, c), o_rd, !wr && c <= beats);
      chk($sformatf("i%0d c%0d ram_wr", inst, c), o_wr, wr && c <= beats);
      chk($sformatf("i%0d c%0d ram_addr", inst, c), o_addr, ea);
      chk($sformatf("i%0d c%0d ram_wdata", inst, c), o_wd, ewd);
      chk($sformatf("i%0d c%0d out_data", inst, c), o_line, exp_out[inst]);
      if (hold && c == lat) begin
        if (inst == 0) sig_wr_a = 0; else sig_wr_b = 0;
      end
    end
  endtask

  initial begin
    RST = 1'b1;
    sig_rd_a = 0; sig_wr_a = 0; sig_rd_b = 0; sig_wr_b = 0;
    in_addr = '0; in_data = '0; salt = '0;
    exp_out[0] = '0; exp_out[1] = '0;

    // Reset state, then idle with no requests.
    repeat (2) @(negedge CLK);
    chk_all_zero(0, "reset a");
    chk_all_zero(1, "reset b");
    RST = 1'b0;
    repeat (6) begin
      @(negedge CLK);
      chk("idle busy a", busy_a, 0);
      chk("idle ack a", ack_a, 0);
      chk("idle busy b", busy_b, 0);
    end

    // Directed read: data = address.
    do_txn(0, 1, 0, 16'h0013, '0, 0);
    chk("read line literal", out_data_a, 128'h0017_0016_0015_0014_0013_0012_0011_0010);

    // Directed write, OUT_DATA must hold the last read line.
    do_txn(0, 0, 1, 16'h0020, 128'h0007_0006_0005_0004_0003_0002_0001_0000, 0);
    chk("line held after write", out_data_a, 128'h0017_0016_0015_0014_0013_0012_0011_0010);

    // Both requests: write wins; held SIG_RD then starts a read right after.
    do_txn(0, 1, 1, 16'h0030, 128'hDEAD_BEEF_0123_4567_89AB_CDEF_5555_AAAA, 1);
    do_txn(0, 1, 0, 16'h0030, '0, 0);

    // Reset in c=5 of a read: outputs drop at once, no ACK follows.
    salt = 16'h1234;
    @(negedge CLK);
    sig_rd_a = 1; in_addr = 16'h0050;
    @(posedge CLK);
    @(negedge CLK);
    sig_rd_a = 0;
    repeat (4) @(negedge CLK);
    RST = 1'b1;
    #1;
    exp_out[0] = '0; exp_out[1] = '0;
    chk_all_zero(0, "mid reset");
    @(negedge CLK);
    RST = 1'b0;
    repeat (8) begin
      @(negedge CLK);
      chk("post reset ack", ack_a, 0);
      chk("post reset busy", busy_a, 0);
    end
    salt = 16'h0000;
    do_txn(0, 1, 0, 16'h0040, '0, 0);

    // Sweep instance: 4 beats, latency 0, wrap at top of address space.
    do_txn(1, 1, 0, 16'hFFFE, '0, 0);
    chk("sweep line literal", out_data_b,
        128'hFFFF_FFFF_FFFE_FFFE_FFFD_FFFD_FFFC_FFFC);

    // Randomized traffic on both instances.
    for (int t = 0; t < 40; t++) begin
      int inst, op, gap;
      logic [15:0] a;
      logic [127:0] d;
      inst = $urandom_range(0, 1);
      op   = $urandom_range(0, 2);
      gap  = $urandom_range(0, 3);
      a    = 16'($urandom);
      d    = {$urandom, $urandom, $urandom, $urandom};
      salt = 16'($urandom);
      repeat (gap) begin
        @(negedge CLK);
        chk("gap busy a", busy_a, 0);
        chk("gap busy b", busy_b, 0);
      end
      do_txn(inst, op != 1, op != 0, a, d, 0);
    end

    repeat (2) @(negedge CLK);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
